// File: rtl/ahb_mtx_output_stage_rr.sv
`default_nettype none
// ============================================================================
// ahb_mtx_output_stage_rr : round-robin AHB matrix output stage with burst hold.
// Optional locked-sequence hold enabled by macro AHB_MTX_OS_LOCK_EN.  Rev 1.0
// ============================================================================
module ahb_mtx_output_stage_rr #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int USER_W    = 32
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic [NUM_PORTS-1:0]        sel_op,
   input  logic [NUM_PORTS-1:0]        held_tran_op,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr_op,
   input  logic [NUM_PORTS*USER_W-1:0] auser_op,
   input  logic [NUM_PORTS*2-1:0]      trans_op,
   input  logic [NUM_PORTS-1:0]        write_op,
   input  logic [NUM_PORTS*3-1:0]      size_op,
   input  logic [NUM_PORTS*3-1:0]      burst_op,
   input  logic [NUM_PORTS*4-1:0]      prot_op,
   input  logic [NUM_PORTS*4-1:0]      master_op,
   input  logic [NUM_PORTS-1:0]        mastlock_op,
   input  logic [NUM_PORTS*DATA_W-1:0] wdata_op,
   input  logic [NUM_PORTS*USER_W-1:0] wuser_op,
   input  logic                        HREADYOUTM,
   output logic [NUM_PORTS-1:0]        active_op,
   output logic                        HSELM,
   output logic                        HWRITEM,
   output logic                        HMASTLOCKM,
   output logic                        HREADYMUXM,
   output logic [ADDR_W-1:0]           HADDRM,
   output logic [USER_W-1:0]           HAUSERM,
   output logic [USER_W-1:0]           HWUSERM,
   output logic [DATA_W-1:0]           HWDATAM,
   output logic [1:0]                  HTRANSM,
   output logic [2:0]                  HSIZEM,
   output logic [2:0]                  HBURSTM,
   output logic [3:0]                  HPROTM,
   output logic [3:0]                  HMASTERM
);

   localparam int                PORT_W    = $clog2(NUM_PORTS);
   localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);
   localparam logic [PORT_W:0]   NUM_P_EXT = (PORT_W+1)'(NUM_PORTS);
   localparam logic [1:0]        TR_IDLE   = 2'b00;
   localparam logic [1:0]        TR_BUSY   = 2'b01;
   localparam logic [1:0]        TR_NONSEQ = 2'b10;
   localparam logic [1:0]        TR_SEQ    = 2'b11;

   logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
   logic [USER_W-1:0] auser_a [NUM_PORTS];
   logic [USER_W-1:0] wuser_a [NUM_PORTS];
   logic [DATA_W-1:0] wdata_a [NUM_PORTS];
   logic [1:0]        trans_a [NUM_PORTS];
   logic [2:0]        size_a  [NUM_PORTS];
   logic [2:0]        burst_a [NUM_PORTS];
   logic [3:0]        prot_a  [NUM_PORTS];
   logic [3:0]        mast_a  [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign addr_a[gi]  = addr_op[gi*ADDR_W +: ADDR_W];
         assign auser_a[gi] = auser_op[gi*USER_W +: USER_W];
         assign wuser_a[gi] = wuser_op[gi*USER_W +: USER_W];
         assign wdata_a[gi] = wdata_op[gi*DATA_W +: DATA_W];
         assign trans_a[gi] = trans_op[gi*2 +: 2];
         assign size_a[gi]  = size_op[gi*3 +: 3];
         assign burst_a[gi] = burst_op[gi*3 +: 3];
         assign prot_a[gi]  = prot_op[gi*4 +: 4];
         assign mast_a[gi]  = master_op[gi*4 +: 4];
      end
   endgenerate

   logic [PORT_W-1:0]    gnt_port_q, gnt_port_d;
   logic                 gnt_vld_q, gnt_vld_d;
   logic [3:0]           beat_cnt_q, beat_cnt_d;
   logic [PORT_W-1:0]    data_port_q;
   logic                 slave_sel_q;
   logic [NUM_PORTS-1:0] w_req;
   logic                 w_hlock_arb;
   logic                 w_burst_hold;
   logic                 w_rr_found;
   logic [PORT_W-1:0]    w_rr_port;
   logic [PORT_W:0]      w_rr_sum;

   assign w_req      = held_tran_op & sel_op;
   assign HREADYMUXM = slave_sel_q ? HREADYOUTM : 1'b1;
   assign HWDATAM    = wdata_a[data_port_q];
   assign HWUSERM    = wuser_a[data_port_q];

   always_comb begin
      active_op  = '0;
      HSELM      = 1'b0;
      HWRITEM    = 1'b0;
      HMASTLOCKM = 1'b0;
      HADDRM     = '0;
      HAUSERM    = '0;
      HTRANSM    = TR_IDLE;
      HSIZEM     = '0;
      HBURSTM    = '0;
      HPROTM     = '0;
      HMASTERM   = '0;
      if (gnt_vld_q) begin
         active_op = NUM_PORTS'(1) << gnt_port_q;
         HSELM     = sel_op[gnt_port_q];
         HWRITEM   = write_op[gnt_port_q];
         HADDRM    = addr_a[gnt_port_q];
         HAUSERM   = auser_a[gnt_port_q];
         HTRANSM   = trans_a[gnt_port_q];
         HSIZEM    = size_a[gnt_port_q];
         HBURSTM   = burst_a[gnt_port_q];
         HPROTM    = prot_a[gnt_port_q];
         HMASTERM  = mast_a[gnt_port_q];
`ifdef AHB_MTX_OS_LOCK_EN
         HMASTLOCKM = mastlock_op[gnt_port_q];
`endif
      end
   end

`ifdef AHB_MTX_OS_LOCK_EN
   logic hsel_lock_q, hsel_lock_d;

   always_comb begin
      hsel_lock_d = hsel_lock_q;
      if (HSELM && HTRANSM[1] && HMASTLOCKM) hsel_lock_d = 1'b1;
      else if (!HMASTLOCKM)                  hsel_lock_d = 1'b0;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)          hsel_lock_q <= 1'b0;
      else if (HREADYMUXM) hsel_lock_q <= hsel_lock_d;
   end

   // hsel_lock keeps the lock alive while the locked master is not selecting us
   assign w_hlock_arb = HMASTLOCKM & (HSELM | hsel_lock_q);
`else
   logic w_unused_lock;
   assign w_unused_lock = ^mastlock_op;
   assign w_hlock_arb   = 1'b0;
`endif

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      case (HTRANSM)
         TR_NONSEQ: if (HSELM) begin
            case (HBURSTM)
               3'b010, 3'b011: beat_cnt_d = 4'd3;
               3'b100, 3'b101: beat_cnt_d = 4'd7;
               3'b110, 3'b111: beat_cnt_d = 4'd15;
               default:        beat_cnt_d = 4'd0;
            endcase
         end
         TR_SEQ:  if (beat_cnt_q != 4'd0) beat_cnt_d = beat_cnt_q - 4'd1;
         TR_BUSY: beat_cnt_d = beat_cnt_q;
         default: beat_cnt_d = 4'd0;
      endcase
   end

   // Hold on the post-beat count so the NONSEQ beat itself keeps the grant
   assign w_burst_hold = (beat_cnt_d != 4'd0) & w_req[gnt_port_q];

   // Descending offsets: the last hit written is the nearest port after gnt_port
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_port  = gnt_port_q;
      w_rr_sum   = '0;
      for (int off = NUM_PORTS; off >= 1; off--) begin
         w_rr_sum = {1'b0, gnt_port_q} + (PORT_W+1)'(off);
         if (w_rr_sum >= NUM_P_EXT) w_rr_sum = w_rr_sum - NUM_P_EXT;
         if (w_req[w_rr_sum[PORT_W-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_port  = w_rr_sum[PORT_W-1:0];
         end
      end
   end

   always_comb begin
      gnt_port_d = gnt_port_q;
      gnt_vld_d  = gnt_vld_q;
      if (!(w_hlock_arb || w_burst_hold)) begin
         if (w_rr_found) begin
            gnt_port_d = w_rr_port;
            gnt_vld_d  = 1'b1;
         end else begin
            gnt_vld_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         gnt_port_q  <= LAST_PORT;
         gnt_vld_q   <= 1'b0;
         beat_cnt_q  <= 4'd0;
         data_port_q <= '0;
         slave_sel_q <= 1'b0;
      end else if (HREADYMUXM) begin
         gnt_port_q  <= gnt_port_d;
         gnt_vld_q   <= gnt_vld_d;
         beat_cnt_q  <= beat_cnt_d;
         data_port_q <= gnt_port_q;
         slave_sel_q <= HSELM;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mtx_output_stage_rr.sv
`default_nettype none
// ============================================================================
// tb_ahb_mtx_output_stage_rr : directed vector bench for the RR output stage.
// Rev 1.0
// ============================================================================
module tb_ahb_mtx_output_stage_rr;

   localparam int NP = 4;

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic [NP-1:0]  sel_op, held_tran_op, write_op, mastlock_op;
   logic [NP*32-1:0] addr_op, auser_op, wdata_op, wuser_op;
   logic [NP*2-1:0]  trans_op;
   logic [NP*3-1:0]  size_op, burst_op;
   logic [NP*4-1:0]  prot_op, master_op;
   logic           HREADYOUTM;
   logic [NP-1:0]  active_op;
   logic           HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
   logic [31:0]    HADDRM, HAUSERM, HWUSERM, HWDATAM;
   logic [1:0]     HTRANSM;
   logic [2:0]     HSIZEM, HBURSTM;
   logic [3:0]     HPROTM, HMASTERM;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] held;
      logic [1:0] trans;
      logic [2:0] burst;
      logic [3:0] exp_act;
      int         exp_dport;
   } vec_t;

   vec_t tbl [17];

   ahb_mtx_output_stage_rr #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .USER_W(32)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .sel_op(sel_op), .held_tran_op(held_tran_op),
      .addr_op(addr_op), .auser_op(auser_op), .trans_op(trans_op), .write_op(write_op),
      .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
      .mastlock_op(mastlock_op), .wdata_op(wdata_op), .wuser_op(wuser_op),
      .HREADYOUTM(HREADYOUTM), .active_op(active_op), .HSELM(HSELM), .HWRITEM(HWRITEM),
      .HMASTLOCKM(HMASTLOCKM), .HREADYMUXM(HREADYMUXM), .HADDRM(HADDRM),
      .HAUSERM(HAUSERM), .HWUSERM(HWUSERM), .HWDATAM(HWDATAM), .HTRANSM(HTRANSM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [31:0] port_addr(input int p);
      return 32'hA000_0000 + 32'(p) * 32'h100;
   endfunction

   function automatic logic [31:0] port_wdata(input int p);
      return 32'hD000_0000 + 32'(p);
   endfunction

   function automatic logic [31:0] exp_addr(input logic [3:0] act);
      logic [31:0] a;
      a = 32'h0;
      for (int p = 0; p < NP; p++) if (act[p]) a = port_addr(p);
      return a;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [3:0] held, input logic [1:0] tr, input logic [2:0] bu);
      held_tran_op = held;
      trans_op     = {NP{tr}};
      burst_op     = {NP{bu}};
   endtask

   task automatic pulse_reset();
      #2 HRESET = 1'b1;
      #1;
      chk("rst async active_op", 64'(active_op), 64'h0);
      chk("rst async HSELM", 64'(HSELM), 64'h0);
      chk("rst async HREADYMUXM", 64'(HREADYMUXM), 64'h1);
      #2 HRESET = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'b0100, 2'b10, 3'b000, 4'b0100, 3};
      tbl[1]  = '{4'b0000, 2'b10, 3'b000, 4'b0000, 2};
      tbl[2]  = '{4'b1011, 2'b10, 3'b000, 4'b1000, 2};
      tbl[3]  = '{4'b1011, 2'b10, 3'b000, 4'b0001, 3};
      tbl[4]  = '{4'b1011, 2'b10, 3'b000, 4'b0010, 0};
      tbl[5]  = '{4'b1011, 2'b10, 3'b000, 4'b1000, 1};
      tbl[6]  = '{4'b1011, 2'b10, 3'b000, 4'b0001, 3};
      tbl[7]  = '{4'b1011, 2'b10, 3'b000, 4'b0010, 0};
      tbl[8]  = '{4'b0011, 2'b10, 3'b011, 4'b0010, 1};
      tbl[9]  = '{4'b0011, 2'b11, 3'b011, 4'b0010, 1};
      tbl[10] = '{4'b0011, 2'b11, 3'b011, 4'b0010, 1};
      tbl[11] = '{4'b0011, 2'b11, 3'b011, 4'b0001, 1};
      tbl[12] = '{4'b0000, 2'b00, 3'b000, 4'b0000, 0};
      tbl[13] = '{4'b0100, 2'b10, 3'b101, 4'b0100, 0};
      tbl[14] = '{4'b0101, 2'b10, 3'b101, 4'b0100, 2};
      tbl[15] = '{4'b0001, 2'b11, 3'b101, 4'b0001, 2};
      tbl[16] = '{4'b0000, 2'b00, 3'b000, 4'b0000, 0};

      HRESET      = 1'b1;
      HREADYOUTM  = 1'b1;
      sel_op      = 4'b1111;
      mastlock_op = 4'b0000;
      write_op    = 4'b1010;
      size_op     = {NP{3'b010}};
      prot_op     = {4'h3, 4'h2, 4'h1, 4'h0};
      master_op   = {4'hC, 4'hB, 4'hA, 4'h9};
      for (int p = 0; p < NP; p++) begin
         addr_op[p*32 +: 32]  = port_addr(p);
         wdata_op[p*32 +: 32] = port_wdata(p);
         auser_op[p*32 +: 32] = 32'h5500_0000 + 32'(p);
         wuser_op[p*32 +: 32] = 32'h6600_0000 + 32'(p);
      end
      drive(4'b0000, 2'b00, 3'b000);

      #23;
      chk("reset active_op", 64'(active_op), 64'h0);
      chk("reset HSELM", 64'(HSELM), 64'h0);
      chk("reset HTRANSM", 64'(HTRANSM), 64'h0);
      chk("reset HMASTLOCKM", 64'(HMASTLOCKM), 64'h0);
      chk("reset HREADYMUXM", 64'(HREADYMUXM), 64'h1);
      chk("reset HADDRM", 64'(HADDRM), 64'h0);
      chk("reset HWDATAM", 64'(HWDATAM), 64'(port_wdata(0)));
      HRESET = 1'b0;
      tick();

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].held, tbl[i].trans, tbl[i].burst);
         tick();
         chk($sformatf("vec%0d active_op", i), 64'(active_op), 64'(tbl[i].exp_act));
         chk($sformatf("vec%0d HSELM", i), 64'(HSELM), 64'(|tbl[i].exp_act));
         chk($sformatf("vec%0d HADDRM", i), 64'(HADDRM), 64'(exp_addr(tbl[i].exp_act)));
         chk($sformatf("vec%0d HTRANSM", i), 64'(HTRANSM),
             64'((tbl[i].exp_act != 4'b0) ? tbl[i].trans : 2'b00));
         chk($sformatf("vec%0d HWDATAM", i), 64'(HWDATAM), 64'(port_wdata(tbl[i].exp_dport)));
         chk($sformatf("vec%0d HREADYMUXM", i), 64'(HREADYMUXM), 64'h1);
      end

      // Slave wait states during port 3 data phase, port 1 waiting
      drive(4'b1000, 2'b10, 3'b000);
      tick();
      chk("ws grant3", 64'(active_op), 64'b1000);
      tick();
      chk("ws data3", 64'(HWDATAM), 64'(port_wdata(3)));
      drive(4'b1010, 2'b10, 3'b000);
      HREADYOUTM = 1'b0;
      #1;
      chk("ws readymux low", 64'(HREADYMUXM), 64'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("ws%0d grant held", k), 64'(active_op), 64'b1000);
         chk($sformatf("ws%0d readymux", k), 64'(HREADYMUXM), 64'h0);
      end
      HREADYOUTM = 1'b1;
      tick();
      chk("ws grant1 after", 64'(active_op), 64'b0010);

      // Reset in the middle of a port 2 WRAP8
      drive(4'b0100, 2'b10, 3'b100);
      tick();
      chk("wrap8 grant2", 64'(active_op), 64'b0100);
      tick();
      drive(4'b0100, 2'b11, 3'b100);
      tick();
      chk("wrap8 held", 64'(active_op), 64'b0100);
      pulse_reset();
      chk("rst HWDATAM", 64'(HWDATAM), 64'(port_wdata(0)));
      drive(4'b0110, 2'b10, 3'b000);
      tick();
      chk("post-rst lowest grant", 64'(active_op), 64'b0010);

      // Locked sequence from port 0 with port 2 competing
      pulse_reset();
      mastlock_op = 4'b0001;
      drive(4'b0101, 2'b10, 3'b000);
      tick();
      chk("lock grant0", 64'(active_op), 64'b0001);
`ifdef AHB_MTX_OS_LOCK_EN
      chk("lock HMASTLOCKM", 64'(HMASTLOCKM), 64'h1);
      tick();
      chk("lock held", 64'(active_op), 64'b0001);
      sel_op = 4'b1110;
      drive(4'b0101, 2'b00, 3'b000);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("lock nosel%0d grant", k), 64'(active_op), 64'b0001);
         chk($sformatf("lock nosel%0d HSELM", k), 64'(HSELM), 64'h0);
      end
      sel_op = 4'b1111;
      drive(4'b0101, 2'b10, 3'b000);
      tick();
      chk("lock reselect held", 64'(active_op), 64'b0001);
      mastlock_op = 4'b0000;
      tick();
      chk("lock released grant2", 64'(active_op), 64'b0100);
`else
      chk("nolock HMASTLOCKM", 64'(HMASTLOCKM), 64'h0);
      tick();
      chk("nolock rr grant2", 64'(active_op), 64'b0100);
`endif
      mastlock_op = 4'b0000;
      drive(4'b0000, 2'b00, 3'b000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
